// File: rtl/dcache_pkg.sv
// Shared types, funct3 encodings and the store-strobe helper for the data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        WT
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-lane enables for an access of the given size at byte offset off.
    function automatic logic [3:0] strobe(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] s;
        case (funct3)
            F3_B, F3_BU: s = 4'b0001 << off;
            F3_H, F3_HU: s = 4'b0011 << {off[1], 1'b0};
            F3_W:        s = 4'b1111;
            default:     s = 4'b1111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dcache_load_align.sv
// Selects the addressed byte/half of a word and sign- or zero-extends it.
module dcache_load_align
    import dcache_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane select then extension; unlisted funct3 codes behave as a full word.
    always_comb begin
        lane_b = word_i[{off_i, 3'b000} +: 8];
        lane_h = word_i[{off_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_B:    result_o = {{24{lane_b[7]}}, lane_b};
            F3_BU:   result_o = {24'd0, lane_b};
            F3_H:    result_o = {{16{lane_h[15]}}, lane_h};
            F3_HU:   result_o = {16'd0, lane_h};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/dcache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
module dcache_dm_wt
    import dcache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned SETS       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [2:0]            cpu_funct3_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_wstrb_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_WIDTH - 2 - IDX_W;

    logic [SETS-1:0]       valid_q;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS];

    state_e state_q, state_d;

    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_wstrb_q, mem_wstrb_d;
    logic [31:0]           hit_cnt_q, hit_cnt_d;
    logic [31:0]           miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [DATA_WIDTH-1:0] merged;
    logic                  fill_en;
    logic                  merge_en;

    // Combinational lookup, lane-replicated store data and the write-hit merge word.
    always_comb begin
        idx = cpu_addr_i[2 +: IDX_W];
        tag = cpu_addr_i[ADDR_WIDTH-1 -: TAG_W];
        hit = valid_q[idx] & (tag_q[idx] == tag);
        case (cpu_funct3_i[1:0])
            2'b00:   st_wdata = {4{cpu_wdata_i[7:0]}};
            2'b01:   st_wdata = {2{cpu_wdata_i[15:0]}};
            default: st_wdata = cpu_wdata_i;
        endcase
        merged = data_q[idx];
        for (int i = 0; i < 4; i++) begin
            if (mem_wstrb_q[i]) merged[8*i +: 8] = mem_wdata_q[8*i +: 8];
        end
    end

    dcache_load_align u_load_align (
        .word_i   (data_q[idx]),
        .off_i    (cpu_addr_i[1:0]),
        .funct3_i (cpu_funct3_i),
        .result_o (cpu_rdata_o)
    );

    // Next-state, stall and backing-memory request logic.
    always_comb begin
        state_d     = state_q;
        stall_o     = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        fill_en     = 1'b0;
        merge_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    if (cpu_we_i) begin
                        stall_o     = 1'b1;
                        state_d     = WT;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_d = st_wdata;
                        mem_wstrb_d = strobe(cpu_funct3_i, cpu_addr_i[1:0]);
                    end else if (hit) begin
                        hit_cnt_d = hit_cnt_q + 32'd1;
                    end else begin
                        stall_o     = 1'b1;
                        miss_cnt_d  = miss_cnt_q + 32'd1;
                        state_d     = MISS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_d = '0;
                        mem_wstrb_d = 4'b0000;
                    end
                end
            end
            MISS: begin
                stall_o = 1'b1;
                if (mem_ack_i) begin
                    fill_en   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            WT: begin
                stall_o = 1'b1;
                if (mem_ack_i) begin
                    // No allocate: only a line already holding this word is updated.
                    merge_en  = hit;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, memory-port and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'b0000;
            hit_cnt_q   <= 32'd0;
            miss_cnt_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Valid bits are the only array state cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // Tag and data arrays: refill on a miss ack, byte merge on a write-hit ack.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= mem_rdata_i;
        end else if (merge_en) begin
            data_q[idx] <= merged;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wstrb_o = mem_wstrb_q;
    assign hit_cnt_o   = hit_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: tb/tb_dcache_dm_wt.sv
// Randomized bench for dcache_dm_wt against a word-memory plus line-occupancy model.
module tb_dcache_dm_wt;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [2:0]  cpu_funct3;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        stall;
    logic        mem_req, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    dcache_dm_wt u_dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req_i    (cpu_req),
        .cpu_we_i     (cpu_we),
        .cpu_funct3_i (cpu_funct3),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_rdata_o  (cpu_rdata),
        .stall_o      (stall),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_wstrb_o  (mem_wstrb),
        .mem_rdata_i  (mem_rdata),
        .mem_ack_i    (mem_ack),
        .hit_cnt_o    (hit_cnt),
        .miss_cnt_o   (miss_cnt)
    );

    // phys_mem is what the DUT writes; ref_mem is what it should contain.
    logic [31:0] phys_mem [1024];
    logic [31:0] ref_mem  [1024];
    int          line_word [16];   // word address held by each line, -1 when empty
    int unsigned ref_hits, ref_misses;
    int          n_checks, n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [11:0] a);
        logic [31:0] w;
        logic [31:0] v;
        int          off;
        w   = ref_mem[a >> 2];
        off = int'(a & 12'd3);
        case (f3)
            3'd0, 3'd4: begin
                v = (w >> (8 * off)) & 32'hff;
                if (f3 == 3'd0 && v >= 32'h80) v = v + 32'hffff_ff00;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * (off / 2))) & 32'hffff;
                if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hffff_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    // Applies a store to ref_mem and returns the strobes/lane data it should produce.
    task automatic ref_store(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd,
                             output logic [3:0] strb, output logic [31:0] lanes);
        logic [31:0] mask;
        int          off;
        off = int'(a & 12'd3);
        if (f3 == 3'd0) begin
            strb  = 4'(1 << off);
            lanes = (wd & 32'hff) * 32'h0101_0101;
        end else if (f3 == 3'd1) begin
            strb  = 4'(3 << (2 * (off / 2)));
            lanes = (wd & 32'hffff) * 32'h0001_0001;
        end else begin
            strb  = 4'hf;
            lanes = wd;
        end
        mask = 0;
        for (int l = 0; l < 4; l++) if (strb[l]) mask = mask | (32'hff << (8 * l));
        ref_mem[a >> 2] = (ref_mem[a >> 2] & ~mask) | (lanes & mask);
    endtask

    // One CPU access; entered and left just after a rising edge.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [11:0] a,
                          input logic [31:0] wd, input int lat, output logic [31:0] rd);
        int          idx, word, stalls;
        bit          hit;
        logic [3:0]  e_strb;
        logic [31:0] e_lanes;
        idx  = int'((a >> 2) & 12'd15);
        word = int'(a >> 2);
        hit  = !we && line_word[idx] == word;
        rd   = 32'd0;
        cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = a; cpu_wdata = wd;
        @(negedge clk);
        if (hit) begin
            check("hit_stall", 32'(stall), 32'd0);
            rd = cpu_rdata;
            check("hit_rdata", rd, ref_load(f3, a));
            ref_hits++;
            @(posedge clk); #1;
        end else begin
            check("first_stall", 32'(stall), 32'd1);
            stalls = 1;
            if (!we) ref_misses++;
            @(posedge clk); #1;
            @(negedge clk);
            check("mem_we", 32'(mem_we), 32'(we));
            check("mem_addr", 32'(mem_addr), 32'(word * 4));
            if (we) begin
                ref_store(f3, a, wd, e_strb, e_lanes);
                check("mem_wstrb", 32'(mem_wstrb), 32'(e_strb));
                check("mem_wdata", mem_wdata, e_lanes);
            end
            for (int i = 0; i <= lat; i++) begin
                if (i > 0) @(negedge clk);
                check("req_hold", 32'(mem_req), 32'd1);
                stalls += int'(stall);
                if (i == lat) begin
                    if (we) begin
                        for (int l = 0; l < 4; l++)
                            if (mem_wstrb[l]) phys_mem[mem_addr >> 2][8*l +: 8] = mem_wdata[8*l +: 8];
                    end else begin
                        mem_rdata = phys_mem[mem_addr >> 2];
                    end
                    mem_ack = 1'b1;
                end
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
            check("stall_cycles", 32'(stalls), 32'(lat + 2));
            check("req_drop", 32'(mem_req), 32'd0);
            if (!we) begin
                line_word[idx] = word;
                @(negedge clk);
                check("refill_stall", 32'(stall), 32'd0);
                rd = cpu_rdata;
                check("refill_rdata", rd, ref_load(f3, a));
                ref_hits++;
                @(posedge clk); #1;
            end
        end
        check("hit_cnt", hit_cnt, 32'(ref_hits));
        check("miss_cnt", miss_cnt, 32'(ref_misses));
        cpu_req = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) line_word[i] = -1;
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    logic [31:0] rd;
    logic [11:0] ra;
    logic [2:0]  rf;
    logic        rw;

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_funct3 = 3'd0; cpu_addr = '0;
        cpu_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            phys_mem[i] = $urandom;
            ref_mem[i]  = phys_mem[i];
        end
        phys_mem[12'h040 >> 2] = 32'hDEAD_BEEF;
        ref_mem[12'h040 >> 2]  = 32'hDEAD_BEEF;
        model_reset();
        #12;
        @(negedge clk);
        rst = 1'b0;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_hits", hit_cnt, 32'd0);
        check("rst_misses", miss_cnt, 32'd0);
        @(posedge clk); #1;

        run_op(1'b0, 3'b010, 12'h040, 32'd0, 3, rd);
        check("lw_miss_const", rd, 32'hDEAD_BEEF);
        check("lw_miss_hits", hit_cnt, 32'd1);
        run_op(1'b0, 3'b010, 12'h040, 32'd0, 0, rd);
        check("lw_hit_const", rd, 32'hDEAD_BEEF);
        run_op(1'b0, 3'b000, 12'h043, 32'd0, 0, rd);
        check("lb_const", rd, 32'hFFFF_FFDE);
        run_op(1'b0, 3'b100, 12'h043, 32'd0, 0, rd);
        check("lbu_const", rd, 32'h0000_00DE);
        run_op(1'b1, 3'b001, 12'h042, 32'h0000_1234, 1, rd);
        run_op(1'b0, 3'b010, 12'h040, 32'd0, 0, rd);
        check("sh_merge_const", rd, 32'h1234_BEEF);
        run_op(1'b1, 3'b000, 12'h080, $urandom, 1, rd);
        run_op(1'b0, 3'b010, 12'h080, 32'd0, 2, rd);
        run_op(1'b0, 3'b010, 12'h0C4, 32'd0, 0, rd);

        // Reset in the middle of a refill: request must drop and a late ack be ignored.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 12'h440;
        @(negedge clk);
        check("alias_miss_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        check("alias_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_req_drop", 32'(mem_req), 32'd0);
        @(negedge clk);
        cpu_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        mem_rdata = $urandom;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_req", 32'(mem_req), 32'd0);
        check("late_ack_hits", hit_cnt, 32'd0);
        check("late_ack_misses", miss_cnt, 32'd0);
        @(posedge clk); #1;
        model_reset();
        run_op(1'b0, 3'b010, 12'h0C4, 32'd0, 0, rd);
        check("post_rst_miss", miss_cnt, 32'd1);
        run_op(1'b0, 3'b010, 12'h440, 32'd0, 1, rd);
        run_op(1'b0, 3'b010, 12'h040, 32'd0, 0, rd);

        for (int n = 0; n < 300; n++) begin
            ra = 12'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) |
                      $urandom_range(0, 3));
            rw = ($urandom_range(0, 3) == 0);
            if (rw) rf = 3'($urandom_range(0, 2));
            else    rf = 3'($urandom_range(0, 7));
            run_op(rw, rf, ra, $urandom, int'($urandom_range(0, 3)), rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
